// File: rtl/queue_gate_control_if.sv
// Gate-control bus: config/sync inputs from the port controller and the gate vector
// presented to the output scheduler.
interface queue_gate_control_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned SW = 11
);
    logic          i_gate_en;
    logic          i_cycle_start;
    logic [SW-1:0] iv_slot_len;
    logic [AW-1:0] iv_gcl_last;
    logic [AW-1:0] iv_gcl_waddr;
    logic [7:0]    iv_gcl_wdata;
    logic          i_gcl_wr;
    logic [7:0]    ov_gate_ctrl_vector;
    logic [AW-1:0] ov_slot_id;
    logic          o_slot_change;

    modport master (
        output i_gate_en, i_cycle_start, iv_slot_len, iv_gcl_last,
               iv_gcl_waddr, iv_gcl_wdata, i_gcl_wr,
        input  ov_gate_ctrl_vector, ov_slot_id, o_slot_change
    );

    modport slave (
        input  i_gate_en, i_cycle_start, iv_slot_len, iv_gcl_last,
               iv_gcl_waddr, iv_gcl_wdata, i_gcl_wr,
        output ov_gate_ctrl_vector, ov_slot_id, o_slot_change
    );
endinterface

// File: rtl/queue_gate_control.sv
// Per-port gate control list executor: steps through GCL entries on a slot-length
// counter, restarting at entry 0 on each time-sync cycle-start pulse.
module queue_gate_control #(
    parameter int unsigned AW       = 5,
    parameter int unsigned SW       = 11,
    parameter logic [7:0]  OPEN_ALL = 8'hFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    queue_gate_control_if.slave   bus_if
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {StIdle, StWaitSync, StRun} state_e;

    state_e        r_state, w_state_d;
    logic [SW-1:0] r_cnt, w_cnt_d;
    logic [AW-1:0] r_slot, w_slot_d;
    logic [7:0]    r_vec, w_vec_d;
    logic          r_chg, w_chg_d;
    logic [7:0]    r_tbl [DEPTH];

    logic [SW-1:0] w_len_eff;
    logic          w_boundary;
    logic [AW-1:0] w_slot_next;
    logic          w_load;
    logic [AW-1:0] w_load_addr;
    logic [7:0]    w_load_vec;

    assign w_len_eff   = (bus_if.iv_slot_len == '0) ? {{(SW-1){1'b0}}, 1'b1} : bus_if.iv_slot_len;
    assign w_boundary  = (r_cnt >= (w_len_eff - {{(SW-1){1'b0}}, 1'b1}));
    // >= also catches a slot left beyond a runtime-shrunk last index
    assign w_slot_next = (r_slot >= bus_if.iv_gcl_last) ? '0 : r_slot + {{(AW-1){1'b0}}, 1'b1};

    // Write-first: a same-cycle config write to the loaded entry wins
    assign w_load_vec = (bus_if.i_gcl_wr && (bus_if.iv_gcl_waddr == w_load_addr))
                      ? bus_if.iv_gcl_wdata : r_tbl[w_load_addr];

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_slot_d    = r_slot;
        w_vec_d     = r_vec;
        w_chg_d     = 1'b0;
        w_load      = 1'b0;
        w_load_addr = '0;

        unique case (r_state)
            StIdle: begin
                w_vec_d  = OPEN_ALL;
                w_slot_d = '0;
                w_cnt_d  = '0;
                if (bus_if.i_gate_en) w_state_d = StWaitSync;
            end
            StWaitSync: begin
                w_vec_d  = OPEN_ALL;
                w_slot_d = '0;
                w_cnt_d  = '0;
                if (!bus_if.i_gate_en) begin
                    w_state_d = StIdle;
                end else if (bus_if.i_cycle_start) begin
                    w_state_d   = StRun;
                    w_load      = 1'b1;
                    w_load_addr = '0;
                end
            end
            StRun: begin
                if (!bus_if.i_gate_en) begin
                    w_state_d = StIdle;
                    w_vec_d   = OPEN_ALL;
                    w_slot_d  = '0;
                    w_cnt_d   = '0;
                end else if (bus_if.i_cycle_start) begin
                    w_load      = 1'b1;
                    w_load_addr = '0;
                end else if (w_boundary) begin
                    w_load      = 1'b1;
                    w_load_addr = w_slot_next;
                end else begin
                    w_cnt_d = r_cnt + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_d = StIdle;
                w_vec_d   = OPEN_ALL;
                w_slot_d  = '0;
                w_cnt_d   = '0;
            end
        endcase

        if (w_load) begin
            w_slot_d = w_load_addr;
            w_vec_d  = w_load_vec;
            w_cnt_d  = '0;
            w_chg_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_slot  <= '0;
            r_vec   <= OPEN_ALL;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_slot  <= w_slot_d;
            r_vec   <= w_vec_d;
            r_chg   <= w_chg_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tbl <= '{default: OPEN_ALL};
        end else if (bus_if.i_gcl_wr) begin
            r_tbl[bus_if.iv_gcl_waddr] <= bus_if.iv_gcl_wdata;
        end
    end

    assign bus_if.ov_gate_ctrl_vector = r_vec;
    assign bus_if.ov_slot_id          = r_slot;
    assign bus_if.o_slot_change       = r_chg;
endmodule

// File: tb/tb_queue_gate_control.sv
// Bench for queue_gate_control: directed test-plan scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_queue_gate_control;
    localparam int unsigned AW = 5;
    localparam int unsigned SW = 11;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #4 clk = ~clk;

    queue_gate_control_if #(.AW(AW), .SW(SW)) bus ();

    queue_gate_control #(.AW(AW), .SW(SW), .OPEN_ALL(8'hFF)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus_if (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 waiting for sync, 2 running the list
    logic [7:0] m_tbl [DEPTH];
    int         m_mode;
    int         m_slot;
    int         m_elapsed;
    logic [7:0] m_vec;
    bit         m_chg;

    function automatic logic [7:0] model_read(int a);
        if (bus.i_gcl_wr && (int'(bus.iv_gcl_waddr) == a)) return bus.iv_gcl_wdata;
        return m_tbl[a];
    endfunction

    task automatic model_load(int a);
        m_slot    = a;
        m_vec     = model_read(a);
        m_elapsed = 0;
        m_chg     = 1'b1;
    endtask

    task automatic model_next();
        int len;
        int last;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = 8'hFF;
            m_mode = 0; m_slot = 0; m_elapsed = 0; m_vec = 8'hFF; m_chg = 1'b0;
            return;
        end
        m_chg = 1'b0;
        len   = (bus.iv_slot_len == 0) ? 1 : int'(bus.iv_slot_len);
        last  = int'(bus.iv_gcl_last);
        case (m_mode)
            0: begin
                m_vec = 8'hFF; m_slot = 0; m_elapsed = 0;
                if (bus.i_gate_en) m_mode = 1;
            end
            1: begin
                m_vec = 8'hFF; m_slot = 0; m_elapsed = 0;
                if (!bus.i_gate_en) m_mode = 0;
                else if (bus.i_cycle_start) begin
                    m_mode = 2;
                    model_load(0);
                end
            end
            default: begin
                if (!bus.i_gate_en) begin
                    m_mode = 0; m_vec = 8'hFF; m_slot = 0; m_elapsed = 0;
                end else if (bus.i_cycle_start) begin
                    model_load(0);
                end else if (m_elapsed + 1 >= len) begin
                    model_load((m_slot >= last) ? 0 : m_slot + 1);
                end else begin
                    m_elapsed++;
                end
            end
        endcase
        if (bus.i_gcl_wr) m_tbl[bus.iv_gcl_waddr] = bus.iv_gcl_wdata;
    endtask

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_vector", int'(bus.ov_gate_ctrl_vector), int'(m_vec));
        chk("model_slot_id", int'(bus.ov_slot_id), m_slot);
        chk("model_slot_change", int'(bus.o_slot_change), int'(m_chg));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic lit(string name, logic [7:0] vec, int slot, bit chg);
        chk({name, "_vec"}, int'(bus.ov_gate_ctrl_vector), int'(vec));
        chk({name, "_slot"}, int'(bus.ov_slot_id), slot);
        chk({name, "_chg"}, int'(bus.o_slot_change), int'(chg));
    endtask

    task automatic write_entry(int a, logic [7:0] d);
        bus.i_gcl_wr     = 1'b1;
        bus.iv_gcl_waddr = AW'(a);
        bus.iv_gcl_wdata = d;
        step();
        bus.i_gcl_wr     = 1'b0;
    endtask

    task automatic pulse_sync();
        bus.i_cycle_start = 1'b1;
        step();
        bus.i_cycle_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] exp2 [13];
    int         sl;

    initial begin
        bus.i_gate_en     = 1'b0;
        bus.i_cycle_start = 1'b0;
        bus.iv_slot_len   = '0;
        bus.iv_gcl_last   = '0;
        bus.iv_gcl_waddr  = '0;
        bus.iv_gcl_wdata  = '0;
        bus.i_gcl_wr      = 1'b0;
        #2;
        do_reset();
        lit("reset", 8'hFF, 0, 1'b0);

        // Enabled but never synchronised: stays open-all
        bus.i_gate_en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        lit("nosync", 8'hFF, 0, 1'b0);

        // Basic three-entry list, slot length 4
        write_entry(0, 8'h01);
        write_entry(1, 8'h82);
        write_entry(2, 8'h40);
        bus.iv_gcl_last = AW'(2);
        bus.iv_slot_len = SW'(4);
        exp2 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h82, 8'h82, 8'h82, 8'h82,
                 8'h40, 8'h40, 8'h40, 8'h40, 8'h01};
        pulse_sync();
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) step();
            lit("list", exp2[k-1], ((k - 1) / 4) % 3, ((k - 1) % 4) == 0);
        end

        // Mid-slot resync
        pulse_sync();
        for (int k = 0; k < 5; k++) step();
        lit("pre_resync", 8'h82, 1, 1'b0);
        pulse_sync();
        lit("resync", 8'h01, 0, 1'b1);
        for (int k = 0; k < 3; k++) step();
        lit("resync_hold", 8'h01, 0, 1'b0);
        step();
        lit("resync_adv", 8'h82, 1, 1'b1);

        // Zero slot length: one cycle per entry
        bus.iv_slot_len = '0;
        bus.iv_gcl_last = AW'(1);
        pulse_sync();
        lit("len0_first", 8'h01, 0, 1'b1);
        for (int k = 1; k < 7; k++) begin
            step();
            lit("len0", (k % 2) ? 8'h82 : 8'h01, k % 2, 1'b1);
        end

        // Disable coinciding with sync and a slot boundary
        bus.iv_slot_len = SW'(4);
        bus.iv_gcl_last = AW'(2);
        pulse_sync();
        for (int k = 0; k < 3; k++) step();
        bus.i_gate_en     = 1'b0;
        bus.i_cycle_start = 1'b1;
        step();
        bus.i_cycle_start = 1'b0;
        lit("disable", 8'hFF, 0, 1'b0);
        step();
        lit("disable_hold", 8'hFF, 0, 1'b0);

        // Write-first bypass on the entry being loaded, then reset mid-slot
        bus.i_gate_en = 1'b1;
        step();
        pulse_sync();
        for (int k = 0; k < 3; k++) step();
        bus.i_gcl_wr     = 1'b1;
        bus.iv_gcl_waddr = AW'(1);
        bus.iv_gcl_wdata = 8'h10;
        step();
        bus.i_gcl_wr = 1'b0;
        lit("bypass", 8'h10, 1, 1'b1);
        step();
        do_reset();
        lit("midreset", 8'hFF, 0, 1'b0);

        // Every entry must read back as open-all after reset
        bus.iv_slot_len = SW'(1);
        bus.iv_gcl_last = AW'(DEPTH - 1);
        step();
        pulse_sync();
        lit("tbl_reset_0", 8'hFF, 0, 1'b1);
        for (int k = 1; k < DEPTH; k++) begin
            step();
            lit("tbl_reset", 8'hFF, k, 1'b1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst               = ($urandom_range(0, 299) == 0);
            bus.i_gate_en     = ($urandom_range(0, 99) < 97);
            bus.i_cycle_start = ($urandom_range(0, 39) == 0);
            bus.i_gcl_wr      = ($urandom_range(0, 5) == 0);
            bus.iv_gcl_waddr  = AW'($urandom_range(0, 7));
            bus.iv_gcl_wdata  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) bus.iv_slot_len = SW'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) bus.iv_gcl_last = AW'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        sl = 0;
        #5000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule

// File: doc/queue_gate_control.md
Name: queue_gate_control

Overview:
- Executes the per-port gate control list (GCL) that produces the 8-bit gate vector consumed by network_output_schedule.
- Each time slot selects one GCL entry; a set bit opens the corresponding queue.
- Slots advance on a cycle counter. The cycle restarts at entry 0 on a global cycle-start pulse from time sync.
- One instance per network interface; 8 queues per interface.

Parameters:
- AW, 5, GCL address width; table depth is 2^AW entries (default 32).
- SW, 11, slot-length counter width in clock cycles.
- OPEN_ALL, 8'hFF, gate vector driven when gating is disabled, idle, or unsynchronised.

Ports:
- i_clk  in  1  125 MHz clock.
- i_rst  in  1  synchronous reset, active-high.
- i_gate_en  in  1  gating enable; 0 forces OPEN_ALL.
- i_cycle_start  in  1  single-cycle pulse marking the start of a gate cycle (from time sync).
- iv_slot_len  in  SW  slot length in cycles; 0 is treated as 1.
- iv_gcl_last  in  AW  index of the last valid GCL entry; the cycle wraps after it.
- iv_gcl_waddr  in  AW  GCL config write address.
- iv_gcl_wdata  in  8  GCL config write data (bit n = queue n open).
- i_gcl_wr  in  1  GCL config write strobe.
- ov_gate_ctrl_vector  out  8  registered gate vector to network_output_schedule.
- ov_slot_id  out  AW  index of the entry currently driving the vector.
- o_slot_change  out  1  one-cycle pulse, asserted in the first cycle a new vector is valid.

Behaviour:
- Storage: internal register table of 2^AW x 8.
- Reset state:
  - all table entries = OPEN_ALL
  - ov_gate_ctrl_vector = OPEN_ALL, ov_slot_id = 0, o_slot_change = 0
  - slot counter = 0, FSM = IDLE
  - Reset takes effect mid-cycle at the next clock edge; there is no partial slot carry-over.
- Table writes:
  - i_gcl_wr writes table[iv_gcl_waddr] at the clock edge, in any state.
  - If the same cycle loads that entry into the output, iv_gcl_wdata is used (write-first bypass).
  - An entry that is already loaded is not retroactively changed; the new value applies from its next load.
- FSM IDLE:
  - Output OPEN_ALL.
  - i_gate_en=1 -> WAIT_SYNC.
- FSM WAIT_SYNC:
  - Output OPEN_ALL.
  - i_gate_en=0 -> IDLE.
  - i_cycle_start=1 -> RUN. Next cycle: ov_slot_id=0, vector=table[0], o_slot_change=1, counter=0.
- FSM RUN:
  - Counter increments each cycle. len_eff = max(iv_slot_len, 1).
  - When counter >= len_eff-1 (>= so a mid-slot shrink cannot be missed):
    - counter <= 0
    - slot <= (slot == iv_gcl_last) ? 0 : slot+1
    - vector <= table[new slot]
    - o_slot_change=1 in the following cycle
  - Each slot therefore holds its vector for exactly len_eff cycles when length is static.
  - If slot > iv_gcl_last (last reduced at runtime), the next advance wraps to 0.
  - i_cycle_start in RUN: resync. Next cycle slot=0, counter=0, vector=table[0], o_slot_change=1. Has priority over a coincident slot advance.
  - i_gate_en=0 -> IDLE: next cycle vector=OPEN_ALL, slot_id=0, o_slot_change=0. Has priority over i_cycle_start and advance.
- Latency: input event at edge k produces its output change visible after edge k+1 (one register stage).
- iv_gcl_last=0: every boundary reloads entry 0 and o_slot_change still pulses.
- o_slot_change is never asserted outside RUN or the cycle entering RUN.
- All arithmetic is unsigned; the counter is SW bits and cannot overflow because len_eff <= 2^SW-1.

Test Plan:
1. Reset then i_gate_en=1 with no i_cycle_start -> vector stays 8'hFF indefinitely, slot_id=0, no o_slot_change.
2. Write table[0..2] = 8'h01, 8'h82, 8'h40; iv_gcl_last=2; iv_slot_len=4; enable; pulse i_cycle_start at cycle T:
   - vector = 01 for T+1..T+4, 82 for T+5..T+8, 40 for T+9..T+12, then 01 from T+13.
   - o_slot_change pulses at T+1, T+5, T+9, T+13.
3. Same setup, pulse i_cycle_start mid-slot 1 at T+6 -> vector = 01 and slot_id=0 at T+7, next advance at T+11.
4. iv_slot_len=0 with iv_gcl_last=1 -> vector alternates between table[0] and table[1] every cycle, o_slot_change high every cycle.
5. In RUN, drop i_gate_en coincident with i_cycle_start and a slot boundary -> next cycle vector=8'hFF, slot_id=0, o_slot_change=0, FSM IDLE.
6. Write table[1]=8'h10 in the same cycle slot 1 is loaded -> vector 8'h10 is output (bypass). Assert i_rst mid-slot -> next cycle vector=8'hFF and all table entries read back as 8'hFF.
